upsamp_ctrl: RTL
================

UPSAMP_CTRL -- requirements
Module: upsamp_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 71: FIR coefficient count loaded per start.
REQ-002 SHALL have parameter SYM_W, default 4: symbol width.
REQ-003 SHALL have parameter COEF_W, default 8: signed coefficient width.
REQ-004 SHALL have port clk  in  1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_start  in  1: start request, one-cycle pulse.
REQ-007 SHALL have port cfg_stop  in  1: stop request, one-cycle pulse.
REQ-008 SHALL have port cfg_rate  in  9: upsampling rate R, sampled only on an accepted start.
REQ-009 SHALL have port coef_in / coef_valid / coef_ready  in COEF_W / in 1 / out 1: coefficient stream, valid/ready handshake.
REQ-010 SHALL have port coef_addr / coef_wdata / coef_we  out 7 / out COEF_W / out 1: FIR coefficient write port.
REQ-011 SHALL have port sym_in / sym_valid / sym_ready  in SYM_W / in 1 / out 1: symbol input handshake.
REQ-012 SHALL have port up_data / up_valid  out SYM_W / out 1: zero-stuffed sample stream into the FIR.
REQ-013 SHALL have port busy / done / underrun / state  out 1 / 1 / 1 / 2: status.

Function
REQ-014 SHALL implement FSM IDLE(0) -> LOAD(1) -> RUN(2) -> DRAIN(3) -> IDLE; state port SHALL show the current encoding.
REQ-015 IDLE: cfg_start SHALL latch R_eff = (cfg_rate < 1) ? 1 : cfg_rate, clear underrun and the tap counter, and enter LOAD; cfg_start in any other state SHALL be ignored.
REQ-016 LOAD: coef_ready SHALL be 1; each coef_valid&coef_ready cycle SHALL register coef_we=1, coef_wdata=coef_in, coef_addr=tap count (0..NUM_TAPS-1) on the next edge.
REQ-017 The write of address NUM_TAPS-1 SHALL move the FSM to RUN with phase=0; coef_we SHALL be 0 on cycles without a handshake.
REQ-018 RUN: sym_ready SHALL be 1 only when phase==0 (combinational from state/phase); phase SHALL increment every cycle and wrap from R_eff-1 to 0.
REQ-019 RUN: up_valid SHALL be registered 1 every cycle. up_data SHALL be sym_in on the cycle after a phase-0 handshake and SHALL be 0 on all other cycles; latency is 1 cycle.
REQ-020 RUN: phase==0 without sym_valid SHALL emit a zero sample and set underrun (sticky until the next accepted start).
REQ-021 cfg_stop in RUN SHALL be held pending until phase==0. Then, with sym_ready forced to 0, the FSM SHALL enter DRAIN.
REQ-022 cfg_stop in IDLE, LOAD or DRAIN SHALL be ignored.
REQ-023 cfg_start and cfg_stop in the same cycle: stop SHALL win in RUN; start SHALL win in IDLE.
REQ-024 DRAIN: SHALL emit exactly NUM_TAPS-1 samples with up_valid=1 and up_data=0, then return to IDLE with done=1 for one cycle.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 coef_valid outside LOAD and sym_valid outside RUN SHALL be ignored and no handshake SHALL occur.
REQ-027 With R_eff=1, sym_ready SHALL be 1 every RUN cycle, so a continuous symbol stream passes with no zeros inserted.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, phase=0, tap count=0, R_eff=1, stop pending=0.
REQ-029 rst_n low SHALL asynchronously force all outputs to 0, including coef_addr, coef_wdata, coef_we, up_data, up_valid, done, underrun and busy.
REQ-030 Reset asserted mid-LOAD/RUN/DRAIN SHALL abort the operation with no further writes or samples; deassertion SHALL take effect on the next clk edge.

Structure
REQ-031 Package upsamp_pkg SHALL hold NUM_TAPS, SYM_W, COEF_W, RATE_W=9 and the state encoding constants.
REQ-032 The phase counter (load R_eff, wrap, phase==0 flag) SHALL be the single sub-module upsamp_phase_cnt; everything else SHALL be flat in upsamp_ctrl.

Verification
REQ-033 Start with cfg_rate=4, 71 back-to-back coefficients 0..70 -> coef_we pulses 71 times, addresses 0..70, wdata equals index, then state=2.
REQ-034 RUN with R=4, symbols 4'hA then 4'h5 always valid -> up_data sequence A,0,0,0,5,0,0,0, first A one cycle after its handshake.
REQ-035 RUN with R=3, sym_valid=0 at a phase-0 slot -> zero sample emitted, underrun=1, and underrun stays set until the next start.
REQ-036 cfg_stop at phase 2 of R=4 -> remaining phases complete, then exactly 70 zero samples, done pulse, state=0.
REQ-037 cfg_rate=0 -> one sample per symbol (R_eff=1), sym_ready continuously 1 in RUN.
REQ-038 rst_n low after 30 coefficient writes -> all outputs 0 immediately; a fresh start reloads from address 0.

Source files
------------

// File: rtl/upsamp_pkg.sv
// Shared constants, state encoding and rate helper for the upsampler controller.
package upsamp_pkg;

  localparam int NUM_TAPS = 71;
  localparam int SYM_W    = 4;
  localparam int COEF_W   = 8;
  localparam int RATE_W   = 9;
  localparam int ADDR_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // A rate of zero is meaningless for zero-stuffing, so it is promoted to 1.
  function automatic logic [RATE_W-1:0] eff_rate(input logic [RATE_W-1:0] rate);
    return (rate == '0) ? RATE_W'(1) : rate;
  endfunction

endpackage

// File: rtl/upsamp_phase_cnt.sv
// Phase counter: holds the effective rate and counts 0..R_eff-1 while enabled.
module upsamp_phase_cnt
  import upsamp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [RATE_W-1:0] rate,
  input  logic              clr,
  input  logic              en,
  output logic [RATE_W-1:0] phase,
  output logic              phase_zero
);

  logic [RATE_W-1:0] r_eff;

  // Latch the rate on load, restart on clr, otherwise advance and wrap at R_eff-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eff <= RATE_W'(1);
      phase <= '0;
    end else if (load) begin
      r_eff <= eff_rate(rate);
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      if (phase >= r_eff - RATE_W'(1)) begin
        phase <= '0;
      end else begin
        phase <= phase + RATE_W'(1);
      end
    end
  end

  assign phase_zero = (phase == '0);

endmodule

// File: rtl/upsamp_ctrl.sv
// Upsampler controller: loads FIR coefficients, then zero-stuffs a symbol
// stream by R_eff, and flushes the FIR with zeros on stop.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on valid, and a source keeps valid/data stable
// until it sees the transfer.
module upsamp_ctrl #(
  parameter int NUM_TAPS = upsamp_pkg::NUM_TAPS,
  parameter int SYM_W    = upsamp_pkg::SYM_W,
  parameter int COEF_W   = upsamp_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [8:0]        cfg_rate,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [6:0]        coef_addr,
  output logic [COEF_W-1:0] coef_wdata,
  output logic              coef_we,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic [SYM_W-1:0]  up_data,
  output logic              up_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [1:0]        state
);

  import upsamp_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(NUM_TAPS - 2);

  state_t            st;
  logic [ADDR_W-1:0] tap_cnt;   // coefficient index in LOAD, flush count in DRAIN
  logic              stop_pend;
  logic [RATE_W-1:0] phase;
  logic              phase_zero;

  logic start_acc;
  logic coef_hs;
  logic sym_hs;
  logic last_tap_wr;
  logic stop_now;

  assign start_acc   = (st == ST_IDLE) && cfg_start;
  assign coef_ready  = (st == ST_LOAD);
  assign coef_hs     = coef_valid && coef_ready;
  assign last_tap_wr = coef_hs && (tap_cnt == LAST_TAP);
  // A pending stop takes the next phase-0 slot instead of a new symbol.
  assign stop_now    = (st == ST_RUN) && phase_zero && stop_pend;
  assign sym_ready   = (st == ST_RUN) && phase_zero && !stop_pend;
  assign sym_hs      = sym_valid && sym_ready;
  assign busy        = (st != ST_IDLE);
  assign state       = st;

  upsamp_phase_cnt u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_acc),
    .rate       (cfg_rate),
    .clr        (last_tap_wr),
    .en         (st == ST_RUN),
    .phase      (phase),
    .phase_zero (phase_zero)
  );

  // Control FSM with registered write-port, sample and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      tap_cnt    <= '0;
      stop_pend  <= 1'b0;
      coef_addr  <= '0;
      coef_wdata <= '0;
      coef_we    <= 1'b0;
      up_data    <= '0;
      up_valid   <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      coef_we  <= 1'b0;
      up_valid <= 1'b0;
      up_data  <= '0;
      done     <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (cfg_start) begin
            underrun  <= 1'b0;
            tap_cnt   <= '0;
            stop_pend <= 1'b0;
            st        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (coef_hs) begin
            coef_we    <= 1'b1;
            coef_wdata <= coef_in;
            coef_addr  <= tap_cnt;
            if (last_tap_wr) begin
              tap_cnt <= '0;
              st      <= ST_RUN;
            end else begin
              tap_cnt <= tap_cnt + ADDR_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (stop_now) begin
            // The stop slot opens no new symbol period, so no sample here.
            stop_pend <= 1'b0;
            tap_cnt   <= '0;
            st        <= ST_DRAIN;
          end else begin
            up_valid <= 1'b1;
            if (sym_hs) begin
              up_data <= sym_in;
            end else if (phase_zero) begin
              underrun <= 1'b1;
            end
            if (cfg_stop) begin
              stop_pend <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          up_valid <= 1'b1;
          if (tap_cnt == LAST_DRAIN) begin
            tap_cnt <= '0;
            done    <= 1'b1;
            st      <= ST_IDLE;
          end else begin
            tap_cnt <= tap_cnt + ADDR_W'(1);
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
